ifu: RTL
========

# ifu

Multi-cycle instruction fetch unit that replaces the single-cycle combinational instruction read in the NPC core. It sits between the PC/commit logic and decode: it issues a handshaked read to instruction memory, buffers the returned word, and presents it to decode with valid/ready. It then waits for the retiring instruction to commit the next PC before fetching again. At most one fetch is in flight; the core does not pipeline.

## Interface

**Parameters**
- `RESET_PC`, default `32'h8000_0000`: first fetch address after reset.
- `TIMEOUT`, default `255`: maximum `S_WAIT` cycles before a bus timeout fault. Range 1..65535.

**Ports**
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `mem_req_valid` output 1: fetch request valid.
- `mem_req_addr` output 32: fetch address, word aligned.
- `mem_req_ready` input 1: memory accepts the request.
- `mem_resp_valid` input 1: read data valid.
- `mem_resp_data` input 32: instruction word.
- `mem_resp_err` input 1: bus error, qualified by `mem_resp_valid`.
- `mem_resp_ready` output 1: IFU accepts the response.
- `inst_valid` output 1: instruction available to decode.
- `inst` output 32: instruction word.
- `inst_pc` output 32: address of `inst`.
- `inst_fault` output 1: `inst` is invalid; fault cause is in `fault_cause`.
- `fault_cause` output 2: 0 none, 1 misaligned PC, 2 bus error, 3 timeout.
- `inst_ready` input 1: decode accepts the instruction.
- `commit_valid` input 1: current instruction retired; `next_pc` is valid.
- `next_pc` input 32: next fetch address (PC+4, branch, JAL or JALR target).
- `fetch_count` output 32: count of instructions delivered to decode.

## Operation

**State machine.** States are `S_IDLE`, `S_REQ`, `S_WAIT`, `S_HOLD`, `S_COMMIT`. Outputs are Moore-style from registered state.
- `S_IDLE`: entered on reset. Moves to `S_REQ` on the first clock edge after reset is released.
- `S_REQ`: drives `mem_req_valid=1` with `mem_req_addr=fetch_pc`.
  - On `mem_req_valid && mem_req_ready`, go to `S_WAIT` and clear the timeout counter.
  - While not accepted, `mem_req_addr` stays stable.
- `S_WAIT`: drives `mem_resp_ready=1`.
  - On `mem_resp_valid`: latch `inst<=mem_resp_data` and `inst_pc<=fetch_pc`. If `mem_resp_err`, set `inst_fault=1`, `fault_cause=2`, `inst=0`. Go to `S_HOLD`.
  - Otherwise the timeout counter increments. When it reaches `TIMEOUT`, set `inst_fault=1`, `fault_cause=3`, `inst=0`, `inst_pc=fetch_pc`, and go to `S_HOLD`.
- `S_HOLD`: drives `inst_valid=1`; `inst`, `inst_pc` and `inst_fault` stay stable. On `inst_ready`, increment `fetch_count` (modulo 2^32) and go to `S_COMMIT`.
- `S_COMMIT`: on `commit_valid`, load `fetch_pc<=next_pc` and clear the fault.
  - If `next_pc[1:0]!=0`: skip memory entirely. Set `inst_fault=1`, `fault_cause=1`, `inst=0`, `inst_pc=next_pc`, and go directly to `S_HOLD`.
  - Otherwise go to `S_REQ`.

**Ignored inputs.**
- `commit_valid` is ignored outside `S_COMMIT`.
- `mem_resp_valid` is ignored outside `S_WAIT`, where `mem_resp_ready=0`.
- A response arriving after a timeout is dropped. Memory must not hold it across the next request.

**Reset values.** All outputs are 0 during reset, except:
- `mem_req_addr=RESET_PC`
- `inst_pc=RESET_PC`
- `fetch_pc=RESET_PC`
- `fetch_count=0`

Reset asserted mid-fetch aborts immediately: `mem_req_valid` and `inst_valid` drop asynchronously. Memory is reset by the same `rst`.

## Timing

- **Best case** (ready and response same cycle, immediate decode handshake, commit one cycle later):
  - REQ at cycle t.
  - WAIT at t+1, response accepted at t+1.
  - `inst_valid` at t+2, handshake at t+2.
  - COMMIT at t+3.
  - Next REQ at t+4.
  - Result: 4 cycles per instruction.
- **Misaligned `next_pc`:** `inst_valid` with fault appears in the cycle after the commit, with no memory request.
- **Timeout:** with no response, the fault appears on `inst_valid` exactly `TIMEOUT+1` cycles after entering `S_WAIT`.
- **`fetch_count`:** updates on the edge ending the `inst_valid && inst_ready` cycle.
- **No combinational paths** from any input to any output.

## Test plan

- **Reset fetch:** release `rst`, memory returns `32'h00100093` one cycle after accepting the request. Required: `mem_req_addr=32'h80000000`; `inst_valid` with `inst=32'h00100093`, `inst_pc=32'h80000000`, `fault_cause=0`.
- **Back-pressure:** hold `mem_req_ready=0` for 5 cycles, then hold `inst_ready=0` for 3 cycles. Required: `mem_req_valid` held with a stable address throughout; `inst` stable during the decode stall; `fetch_count` goes 0→1 only after the handshake.
- **Branch redirect:** commit with `next_pc=32'h80000040`. Required: the next `mem_req_addr=32'h80000040`. Asserting `commit_valid` during `S_HOLD` has no effect.
- **Misaligned target:** commit with `next_pc=32'h80000042`. Required: no `mem_req_valid`; next cycle `inst_valid=1`, `inst_fault=1`, `fault_cause=1`, `inst_pc=32'h80000042`.
- **Bus error and timeout:**
  - Return `mem_resp_err=1`. Required: `fault_cause=2`, `inst=0`.
  - With `TIMEOUT=4` and no response: `fault_cause=3` exactly 5 cycles after `S_WAIT` entry. A late response is ignored.
- **Reset mid-wait and counter wrap:**
  - Assert `rst` in `S_WAIT`. Required: outputs return to reset values immediately; the fetch restarts at `RESET_PC`.
  - Preload the count to `32'hFFFFFFFF` by force, then deliver one instruction. Required: `fetch_count=0`.

Source files
------------

// File: rtl/ifu.sv
// ifu: multi-cycle instruction fetch unit for the NPC core.
// Issues one handshaked fetch, buffers the word, hands it to decode, waits for commit.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   mem_req_*                fetch request (valid/ready, word address)
//   mem_resp_*               fetch response (valid/ready, data, bus error)
//   inst_valid/inst_ready    handshake to decode; inst, inst_pc, inst_fault, fault_cause
//   commit_valid, next_pc    retiring instruction supplies the next fetch address
//   fetch_count              instructions delivered to decode (wraps at 2^32)
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        mem_resp_err,
  output logic        mem_resp_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  output logic [1:0]  fault_cause,
  input  logic        inst_ready,
  input  logic        commit_valid,
  input  logic [31:0] next_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_COMMIT
  } state_t;

  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_ALIGN = 2'd1;
  localparam logic [1:0] C_BUS   = 2'd2;
  localparam logic [1:0] C_TMO   = 2'd3;

  localparam logic [15:0] TMO_MAX = 16'(TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;
  logic [15:0] tmo_q, tmo_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    fault_d       = fault_q;
    cause_d       = cause_q;
    tmo_d         = tmo_q;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        if (mem_req_ready) begin
          state_d = S_WAIT;
          tmo_d   = '0;
        end
      end

      S_WAIT: begin
        if (mem_resp_valid) begin
          state_d   = S_HOLD;
          inst_pc_d = fetch_pc_q;
          if (mem_resp_err) begin
            inst_d  = '0;
            fault_d = 1'b1;
            cause_d = C_BUS;
          end else begin
            inst_d  = mem_resp_data;
            fault_d = 1'b0;
            cause_d = C_NONE;
          end
        end else if (tmo_q == TMO_MAX) begin
          // counter reached the limit with nothing returned:
          // present a timeout fault; any later response is dropped
          state_d   = S_HOLD;
          inst_d    = '0;
          inst_pc_d = fetch_pc_q;
          fault_d   = 1'b1;
          cause_d   = C_TMO;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      S_HOLD: begin
        if (inst_ready) begin
          state_d       = S_COMMIT;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end

      S_COMMIT: begin
        if (commit_valid) begin
          fetch_pc_d = next_pc;
          fault_d    = 1'b0;
          cause_d    = C_NONE;
          if (next_pc[1:0] != 2'b00) begin
            // misaligned target never reaches memory
            state_d   = S_HOLD;
            inst_d    = '0;
            inst_pc_d = next_pc;
            fault_d   = 1'b1;
            cause_d   = C_ALIGN;
          end else begin
            state_d = S_REQ;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      fetch_pc_q    <= RESET_PC;
      inst_q        <= '0;
      inst_pc_q     <= RESET_PC;
      fault_q       <= 1'b0;
      cause_q       <= C_NONE;
      tmo_q         <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
      fault_q       <= fault_d;
      cause_q       <= cause_d;
      tmo_q         <= tmo_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Moore outputs only: nothing here depends on an input
  assign mem_req_valid  = (state_q == S_REQ);
  assign mem_req_addr   = fetch_pc_q;
  assign mem_resp_ready = (state_q == S_WAIT);
  assign inst_valid     = (state_q == S_HOLD);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign inst_fault     = fault_q;
  assign fault_cause    = cause_q;
  assign fetch_count    = fetch_count_q;

endmodule
